// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the pipelined instruction memory
//   TEXT_MEM_SIZE : text segment size in bytes (default memory depth source)
//   imem_err_e    : response status code
//   imem_resp_t   : one response entry {data, err}
package imem_pkg;
  localparam int TEXT_MEM_SIZE = 1024;
  localparam int IMEM_XLEN = 32;
  typedef enum logic [1:0] {
    IMEM_OK           = 2'd0,
    IMEM_MISALIGNED   = 2'd1,
    IMEM_OUT_OF_RANGE = 2'd2
  } imem_err_e;
  typedef struct packed {
    logic [IMEM_XLEN-1:0] data;
    imem_err_e            err;
  } imem_resp_t;
endpackage

// File: rtl/imem_if.sv
// imem_if: fetch request/response bus between the fetch stage and imem_pipelined
//   req_valid/req_addr/req_ready    : request handshake
//   resp_valid/resp_data/resp_err/resp_ready : response handshake
//   flush                           : discard all pending responses
//   master = fetch side, slave = memory side
interface imem_if #(parameter int WIDTH = 32);
  import imem_pkg::*;
  logic             req_valid;
  logic [WIDTH-1:0] req_addr;
  logic             req_ready;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  imem_err_e        resp_err;
  logic             flush;
  modport master (output req_valid, req_addr, resp_ready, flush,
                  input  req_ready, resp_valid, resp_data, resp_err);
  modport slave  (input  req_valid, req_addr, resp_ready, flush,
                  output req_ready, resp_valid, resp_data, resp_err);
endinterface

// File: rtl/imem_resp_fifo.sv
// imem_resp_fifo: DEPTH-entry response queue with synchronous clear
//   clk, rst_n      : clock, async active-low reset
//   clr             : drop all entries (wins over a same-cycle write/read)
//   wr_en, wr_data  : push; caller guarantees space
//   rd_en, rd_data  : pop head; rd_data is the current head
//   empty, count    : occupancy
module imem_resp_fifo
  import imem_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = imem_resp_t,
  localparam int PW    = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  T              wr_data,
  input  logic          rd_en,
  output T              rd_data,
  output logic          empty,
  output logic [CW-1:0] count
);
  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          do_rd;
  always_comb begin
    do_rd    = rd_en && (count_q != '0);
    wr_ptr_d = clr ? '0 : !wr_en ? wr_ptr_q : (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d = clr ? '0 : !do_rd ? rd_ptr_q : (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    count_d  = clr ? '0 : count_q + CW'(wr_en) - CW'(do_rd);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem_q[wr_ptr_q] <= wr_data;
  end
  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;
endmodule

// File: rtl/imem_pipelined.sv
// imem_pipelined: instruction memory with registered read, latency pipeline and credit-limited response queue
//   clk, rst_n          : clock, async active-low reset
//   bus (imem_if.slave) : request/response handshake plus flush
//   ld_en, ld_word_idx, ld_data : loader word write port
module imem_pipelined
  import imem_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               DEPTH_WORDS  = TEXT_MEM_SIZE / 4,
  parameter logic [WIDTH-1:0] BASE_ADDR    = '0,
  parameter int               READ_LATENCY = 1,
  parameter int               RESP_DEPTH   = 2,
  parameter string            INIT_FILE    = "",
  localparam int              IW           = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_if.slave            bus,
  input  logic             ld_en,
  input  logic [IW-1:0]    ld_word_idx,
  input  logic [WIDTH-1:0] ld_data
);
  localparam int             CW       = $clog2(RESP_DEPTH + 1);
  localparam logic [WIDTH:0] END_ADDR = {1'b0, BASE_ADDR} + (WIDTH+1)'(4 * DEPTH_WORDS);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    imem_err_e        err;
  } resp_t;
  logic [WIDTH-1:0] mem_q [DEPTH_WORDS];
  resp_t            cur, wr_r, head;
  logic             accept, pop, wr_v, empty, req_ready;
  logic [CW-1:0]    inflight, queued, outstanding;
  logic [IW-1:0]    widx;
  always_ff @(posedge clk) begin
    if (ld_en && ({1'b0, ld_word_idx} < (IW+1)'(DEPTH_WORDS))) mem_q[ld_word_idx] <= ld_data;
  end
  // The word is read here, at accept time, so a same-edge loader write is not visible to it.
  always_comb begin
    widx     = IW'((bus.req_addr - BASE_ADDR) >> 2);
    cur.err  = (bus.req_addr[1:0] != 2'b00) ? IMEM_MISALIGNED
             : (bus.req_addr < BASE_ADDR || {1'b0, bus.req_addr} >= END_ADDR) ? IMEM_OUT_OF_RANGE
             : IMEM_OK;
    cur.data = (cur.err == IMEM_OK) ? mem_q[widx] : '0;
  end
  // Credits cover both pipeline stages and queued entries, so the queue can never overflow.
  assign outstanding    = inflight + queued;
  assign req_ready      = !bus.flush && (outstanding < CW'(RESP_DEPTH));
  assign accept         = bus.req_valid && req_ready;
  assign pop            = !empty && bus.resp_ready && !bus.flush;
  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = !empty;
  assign bus.resp_data  = empty ? '0 : head.data;
  assign bus.resp_err   = empty ? IMEM_OK : head.err;
  // The queue write is the last of READ_LATENCY registers, so only READ_LATENCY-1 extra stages are needed.
  if (READ_LATENCY == 1) begin : g_nopipe
    assign wr_v     = accept;
    assign wr_r     = cur;
    assign inflight = '0;
  end else begin : g_pipe
    localparam int S = READ_LATENCY - 1;
    logic  [S-1:0] pipe_v_d, pipe_v_q;
    resp_t [S-1:0] pipe_r_d, pipe_r_q;
    always_comb begin
      pipe_v_d[0] = accept;
      pipe_r_d[0] = cur;
      for (int i = 1; i < S; i++) begin
        pipe_v_d[i] = pipe_v_q[i-1];
        pipe_r_d[i] = pipe_r_q[i-1];
      end
      if (bus.flush) pipe_v_d = '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_v_q <= '0;
        pipe_r_q <= '0;
      end else begin
        pipe_v_q <= pipe_v_d;
        pipe_r_q <= pipe_r_d;
      end
    end
    assign wr_v     = pipe_v_q[S-1];
    assign wr_r     = pipe_r_q[S-1];
    assign inflight = CW'($countones(pipe_v_q));
  end
  imem_resp_fifo #(.DEPTH(RESP_DEPTH), .T(resp_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (bus.flush),
    .wr_en   (wr_v),
    .wr_data (wr_r),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (empty),
    .count   (queued)
  );
endmodule
